// File: rtl/pcie_tlp_pkg.sv
// Shared TLP constants, FSM state encoding and registered request record
// for the AXI-Stream TX TLP generator.
package pcie_tlp_pkg;

    localparam logic [7:0] FMT_TYPE_MWR32 = 8'h40;
    localparam logic [7:0] FMT_TYPE_CPLD  = 8'h4A;

    localparam int unsigned LEN_W = 10;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned ID_W  = 16;
    localparam int unsigned BC_W  = 12;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StHdr2,
        StData
    } tx_state_e;

    typedef struct packed {
        logic              req_type;
        logic [31:0]       addr;
        logic [LEN_W-1:0]  len;
        logic [TAG_W-1:0]  tag;
        logic [ID_W-1:0]   requester_id;
        logic [BC_W-1:0]   byte_count;
        logic [ID_W-1:0]   local_id;
    } tlp_req_t;

    // A zero length field encodes the maximum payload of 1024 DW.
    function automatic logic [CNT_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
        return (len == '0) ? CNT_W'(1024) : {1'b0, len};
    endfunction

endpackage

// File: rtl/pcie_tx_hdr_fmt.sv
// Combinational 3-DW header builder for MWr32 and CplD TLPs.
module pcie_tx_hdr_fmt
    import pcie_tlp_pkg::*;
(
    input  tlp_req_t    req_i,
    output logic [31:0] dw0_o,
    output logic [31:0] dw1_o,
    output logic [31:0] dw2_o
);

    logic [3:0] last_be;

    always_comb begin
        // A single-DW write carries all its enables in first BE.
        last_be = (req_i.len == LEN_W'(1)) ? 4'h0 : 4'hF;
        if (req_i.req_type) begin
            dw0_o = {FMT_TYPE_CPLD, 8'h00, 6'b0, req_i.len};
            dw1_o = {req_i.local_id, 3'b000, 1'b0, req_i.byte_count};
            dw2_o = {req_i.requester_id, req_i.tag, 1'b0, req_i.addr[6:0]};
        end else begin
            dw0_o = {FMT_TYPE_MWR32, 8'h00, 6'b0, req_i.len};
            dw1_o = {req_i.local_id, req_i.tag, last_be, 4'hF};
            dw2_o = {req_i.addr[31:2], 2'b00};
        end
    end

endmodule

// File: rtl/pcie_axi_tx_tlp_gen.sv
// Streams a MWr32 or CplD TLP (3 header DW + payload) onto the PCIe core's
// AXI4-Stream TX port, arbitrating against configuration-space access.
module pcie_axi_tx_tlp_gen
    import pcie_tlp_pkg::*;
#(
    parameter int unsigned BUF_AV_MIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_cfg_bus_number,
    input  logic [4:0]  i_cfg_device_number,
    input  logic [2:0]  i_cfg_function_number,
    input  logic        i_req_stb,
    output logic        o_req_ack,
    input  logic        i_req_type,
    input  logic [31:0] i_req_addr,
    input  logic [9:0]  i_req_dword_count,
    input  logic [7:0]  i_req_tag,
    input  logic [15:0] i_req_requester_id,
    input  logic [11:0] i_req_byte_count,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    output logic [31:0] s_axis_tx_tdata,
    output logic [3:0]  s_axis_tx_tkeep,
    output logic [3:0]  s_axis_tx_tuser,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    input  logic [5:0]  tx_buf_av,
    input  logic        tx_err_drop,
    input  logic        tx_cfg_req,
    output logic        tx_cfg_gnt,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err_drop
);

    tx_state_e        state_q, state_d;
    tlp_req_t         req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_drop_q, err_drop_d;
    logic             accept, data_fire, last_fire;
    logic [31:0]      hdr_dw0, hdr_dw1, hdr_dw2;

    pcie_tx_hdr_fmt u_hdr_fmt (
        .req_i (req_q),
        .dw0_o (hdr_dw0),
        .dw1_o (hdr_dw1),
        .dw2_o (hdr_dw2)
    );

    always_comb begin
        accept    = (state_q == StIdle) && i_req_stb && !tx_cfg_req &&
                    (32'(tx_buf_av) >= BUF_AV_MIN);
        data_fire = (state_q == StData) && i_data_valid && s_axis_tx_tready;
        last_fire = data_fire && (cnt_q == CNT_W'(1));

        o_req_ack  = accept && !rst;
        o_done     = last_fire && !rst;
        tx_cfg_gnt = (state_q == StIdle) && tx_cfg_req && !rst;
        o_busy     = (state_q != StIdle);
        o_err_drop = err_drop_q;

        s_axis_tx_tkeep  = 4'hF;
        s_axis_tx_tuser  = 4'h0;
        s_axis_tx_tvalid = 1'b0;
        s_axis_tx_tdata  = '0;
        o_data_ready     = 1'b0;
        unique case (state_q)
            StHdr0: begin
                s_axis_tx_tvalid = 1'b1;
                s_axis_tx_tdata  = hdr_dw0;
            end
            StHdr1: begin
                s_axis_tx_tvalid = 1'b1;
                s_axis_tx_tdata  = hdr_dw1;
            end
            StHdr2: begin
                s_axis_tx_tvalid = 1'b1;
                s_axis_tx_tdata  = hdr_dw2;
            end
            StData: begin
                // Payload is a zero-latency pass-through of the source handshake.
                s_axis_tx_tvalid = i_data_valid;
                s_axis_tx_tdata  = i_data;
                o_data_ready     = s_axis_tx_tready;
            end
            default: ;
        endcase
        s_axis_tx_tlast = (state_q == StData) && (cnt_q == CNT_W'(1)) && s_axis_tx_tvalid;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        // A drop reported in the acknowledge cycle must survive the clear.
        err_drop_d = tx_err_drop | (err_drop_q & ~accept);
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d            = StHdr0;
                    req_d.req_type     = i_req_type;
                    req_d.addr         = i_req_addr;
                    req_d.len          = i_req_dword_count;
                    req_d.tag          = i_req_tag;
                    req_d.requester_id = i_req_requester_id;
                    req_d.byte_count   = i_req_byte_count;
                    req_d.local_id     = {i_cfg_bus_number, i_cfg_device_number,
                                          i_cfg_function_number};
                    cnt_d              = len_to_beats(i_req_dword_count);
                end
            end
            StHdr0: if (s_axis_tx_tready) state_d = StHdr1;
            StHdr1: if (s_axis_tx_tready) state_d = StHdr2;
            StHdr2: if (s_axis_tx_tready) state_d = StData;
            StData: begin
                if (data_fire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last_fire) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= '0;
            cnt_q      <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            err_drop_q <= err_drop_d;
        end
    end

endmodule

// File: tb/tb_pcie_axi_tx_tlp_gen.sv
// Randomized self-checking bench: a transaction-level model predicts every
// accepted AXI beat, plus per-cycle handshake, grant, busy and drop-flag checks.
`timescale 1ns/1ps
module tb_pcie_axi_tx_tlp_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_cfg_bus_number = 8'h0;
    logic [4:0]  i_cfg_device_number = 5'h0;
    logic [2:0]  i_cfg_function_number = 3'h0;
    logic        i_req_stb = 1'b0;
    logic        o_req_ack;
    logic        i_req_type = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [9:0]  i_req_dword_count = '0;
    logic [7:0]  i_req_tag = '0;
    logic [15:0] i_req_requester_id = '0;
    logic [11:0] i_req_byte_count = '0;
    logic [31:0] i_data = '0;
    logic        i_data_valid = 1'b0;
    logic        o_data_ready;
    logic [31:0] s_axis_tx_tdata;
    logic [3:0]  s_axis_tx_tkeep;
    logic [3:0]  s_axis_tx_tuser;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready = 1'b1;
    logic [5:0]  tx_buf_av = 6'd2;
    logic        tx_err_drop = 1'b0;
    logic        tx_cfg_req = 1'b0;
    logic        tx_cfg_gnt;
    logic        o_busy;
    logic        o_done;
    logic        o_err_drop;

    pcie_axi_tx_tlp_gen #(.BUF_AV_MIN(2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_cfg_bus_number      (i_cfg_bus_number),
        .i_cfg_device_number   (i_cfg_device_number),
        .i_cfg_function_number (i_cfg_function_number),
        .i_req_stb             (i_req_stb),
        .o_req_ack             (o_req_ack),
        .i_req_type            (i_req_type),
        .i_req_addr            (i_req_addr),
        .i_req_dword_count     (i_req_dword_count),
        .i_req_tag             (i_req_tag),
        .i_req_requester_id    (i_req_requester_id),
        .i_req_byte_count      (i_req_byte_count),
        .i_data                (i_data),
        .i_data_valid          (i_data_valid),
        .o_data_ready          (o_data_ready),
        .s_axis_tx_tdata       (s_axis_tx_tdata),
        .s_axis_tx_tkeep       (s_axis_tx_tkeep),
        .s_axis_tx_tuser       (s_axis_tx_tuser),
        .s_axis_tx_tlast       (s_axis_tx_tlast),
        .s_axis_tx_tvalid      (s_axis_tx_tvalid),
        .s_axis_tx_tready      (s_axis_tx_tready),
        .tx_buf_av             (tx_buf_av),
        .tx_err_drop           (tx_err_drop),
        .tx_cfg_req            (tx_cfg_req),
        .tx_cfg_gnt            (tx_cfg_gnt),
        .o_busy                (o_busy),
        .o_done                (o_done),
        .o_err_drop            (o_err_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] pay_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ready_mode = 0;
    bit          rand_side = 1'b0;
    bit          pkt_active = 1'b0;
    bit          err_m = 1'b0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          pkt_beats = 0;
    int          data_beats = 0;
    int          last_pkt_beats = 0;
    int          exp_len = 0;
    bit          data_fire_n = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_tdata = '0;
    bit          exp_ack, beat_fire;
    beat_t       b;
    logic [31:0] junk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor and cycle-level reference model, sampled away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_ack", o_req_ack, 0);
            check_eq("rst_done", o_done, 0);
            check_eq("rst_gnt", tx_cfg_gnt, 0);
            pkt_active  = 1'b0;
            err_m       = 1'b0;
            prev_stall  = 1'b0;
            data_fire_n = 1'b0;
        end else begin
            exp_ack = !pkt_active && i_req_stb && !tx_cfg_req && (tx_buf_av >= 6'd2);
            check_eq("ack", o_req_ack, exp_ack);
            check_eq("gnt", tx_cfg_gnt, !pkt_active && tx_cfg_req);
            check_eq("busy", o_busy, pkt_active);
            check_eq("err_drop", o_err_drop, err_m);
            if (!pkt_active) begin
                check_eq("ready_idle", o_data_ready, 0);
                check_eq("tvalid_idle", s_axis_tx_tvalid, 0);
            end
            if (prev_stall) begin
                check_eq("hold_valid", s_axis_tx_tvalid, 1);
                check_eq("hold_data", s_axis_tx_tdata, prev_tdata);
            end
            beat_fire   = s_axis_tx_tvalid && s_axis_tx_tready;
            data_fire_n = i_data_valid && o_data_ready;
            if (beat_fire) begin
                pkt_beats++;
                if (pkt_beats > 3) data_beats++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check_eq("tdata", s_axis_tx_tdata, b.data);
                    check_eq("tlast", s_axis_tx_tlast, b.last);
                    check_eq("done", o_done, b.last);
                    check_eq("tkeep_tuser", {s_axis_tx_tkeep, s_axis_tx_tuser}, 8'hF0);
                    if (b.last) begin
                        done_cnt++;
                        last_pkt_beats = pkt_beats;
                        pkt_active     = 1'b0;
                    end
                end
            end else begin
                check_eq("done_idle", o_done, 0);
            end
            prev_stall = s_axis_tx_tvalid && !s_axis_tx_tready;
            prev_tdata = s_axis_tx_tdata;
            err_m = tx_err_drop ? 1'b1 : (exp_ack ? 1'b0 : err_m);
            if (exp_ack) begin
                pkt_active = 1'b1;
                ack_cnt++;
                pkt_beats  = 0;
                data_beats = 0;
            end
        end
    end

    // Sink backpressure, payload source and random side-band traffic.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       s_axis_tx_tready = 1'b1;
            1:       s_axis_tx_tready = ~s_axis_tx_tready;
            default: s_axis_tx_tready = ($urandom % 4) != 0;
        endcase
        if (data_fire_n && pay_q.size() > 0) begin
            junk         = pay_q.pop_front();
            i_data_valid = 1'b0;
        end
        if (!i_data_valid && pay_q.size() > 0 && ($urandom % 4) != 0) begin
            i_data_valid = 1'b1;
            i_data       = pay_q[0];
        end
        if (rand_side) begin
            tx_buf_av   = (($urandom % 4) == 0) ? 6'($urandom % 3) : 6'($urandom_range(2, 63));
            tx_cfg_req  = ($urandom % 8) == 0;
            tx_err_drop = ($urandom % 16) == 0;
        end
    end

    task automatic prep(input bit typ, input logic [31:0] addr, input logic [9:0] len,
                        input logic [7:0] tag, input logic [15:0] rid, input logic [11:0] bc);
        int          n;
        logic [31:0] id, h0, h1, h2, w;
        i_req_type         = typ;
        i_req_addr         = addr;
        i_req_dword_count  = len;
        i_req_tag          = tag;
        i_req_requester_id = rid;
        i_req_byte_count   = bc;
        id = 32'(i_cfg_bus_number) * 256 + 32'(i_cfg_device_number) * 8
             + 32'(i_cfg_function_number);
        n  = (len == 0) ? 1024 : int'(len);
        if (!typ) begin
            h0 = 32'h4000_0000 + 32'(len);
            h1 = id * 65536 + 32'(tag) * 256 + ((n == 1) ? 32'h0F : 32'hFF);
            h2 = addr & 32'hFFFF_FFFC;
        end else begin
            h0 = 32'h4A00_0000 + 32'(len);
            h1 = id * 65536 + 32'(bc);
            h2 = 32'(rid) * 65536 + 32'(tag) * 256 + (addr % 128);
        end
        exp_q.push_back('{h0, 1'b0});
        exp_q.push_back('{h1, 1'b0});
        exp_q.push_back('{h2, 1'b0});
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            pay_q.push_back(w);
            exp_q.push_back('{w, i == n - 1});
        end
        exp_len = n;
    endtask

    task automatic recover();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.delete();
        pay_q.delete();
        i_data_valid = 1'b0;
        i_req_stb    = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        int a0;
        a0 = ack_cnt;
        i_req_stb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (ack_cnt != a0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        i_req_stb = 1'b0;
        if (!ok) begin
            check_eq("ack_timeout", 0, 1);
            recover();
        end
    endtask

    task automatic run_req();
        int d0;
        bit ok;
        d0 = done_cnt;
        wait_ack(ok);
        if (!ok) return;
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            check_eq("done_timeout", 0, 1);
            recover();
            return;
        end
        check_eq("beat_count", last_pkt_beats, exp_len + 3);
        check_eq("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        int d0;
        tx_cfg_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_tvalid", s_axis_tx_tvalid, 0);
        check_eq("reset_tlast", s_axis_tx_tlast, 0);
        check_eq("reset_tdata", s_axis_tx_tdata, 0);
        check_eq("reset_busy", o_busy, 0);
        check_eq("reset_err", o_err_drop, 0);
        check_eq("reset_ready", o_data_ready, 0);
        check_eq("reset_gnt", tx_cfg_gnt, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        tx_cfg_req = 1'b0;

        i_cfg_bus_number      = 8'h12;
        i_cfg_device_number   = 5'h03;
        i_cfg_function_number = 3'h1;
        ready_mode = 0;
        prep(1'b0, 32'h0000_1004, 10'd1, 8'hA5, 16'h0, 12'h0);
        run_req();
        prep(1'b1, 32'h0000_0010, 10'd4, 8'h05, 16'hBEEF, 12'd16);
        run_req();

        ready_mode = 1;
        prep(1'b0, 32'h8000_0ABF, 10'd6, 8'h33, 16'h0, 12'h0);
        run_req();
        prep(1'b1, 32'h1234_567F, 10'd3, 8'h7E, 16'h0102, 12'd12);
        run_req();

        ready_mode = 0;
        prep(1'b0, 32'h0000_2000, 10'd2, 8'h44, 16'h0, 12'h0);
        @(posedge clk);
        #1;
        tx_cfg_req = 1'b1;
        i_req_stb  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("cfg_gnt", tx_cfg_gnt, 1);
            check_eq("cfg_block_ack", o_req_ack, 0);
        end
        @(posedge clk);
        #1;
        tx_cfg_req = 1'b0;
        tx_buf_av  = 6'd1;
        repeat (4) begin
            @(negedge clk);
            check_eq("bufav_block_ack", o_req_ack, 0);
            check_eq("bufav_gnt", tx_cfg_gnt, 0);
        end
        @(posedge clk);
        #1;
        tx_buf_av = 6'd2;
        run_req();

        ready_mode = 2;
        prep(1'b0, 32'hCAFE_0000, 10'd0, 8'h10, 16'h0, 12'h0);
        run_req();

        prep(1'b1, 32'h0000_0055, 10'd0, 8'h20, 16'h4321, 12'd0);
        d0 = done_cnt;
        wait_ack(ok);
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 800; i++) begin
                @(posedge clk);
                if (data_beats >= 10) begin
                    ok = 1'b1;
                    break;
                end
            end
            check_eq("beat10_reached", ok, 1);
            #1;
            rst          = 1'b1;
            i_data_valid = 1'b0;
            pay_q.delete();
            exp_q.delete();
            @(posedge clk);
            @(negedge clk);
            check_eq("midrst_tvalid", s_axis_tx_tvalid, 0);
            check_eq("midrst_tlast", s_axis_tx_tlast, 0);
            check_eq("midrst_busy", o_busy, 0);
            check_eq("midrst_ready", o_data_ready, 0);
            check_eq("midrst_done", o_done, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_eq("midrst_no_done", done_cnt, d0);
        end

        ready_mode = 0;
        prep(1'b0, 32'h0000_3000, 10'd8, 8'h61, 16'h0, 12'h0);
        fork
            run_req();
            begin
                repeat (5) @(posedge clk);
                #1;
                tx_err_drop = 1'b1;
                @(posedge clk);
                #1;
                tx_err_drop = 1'b0;
            end
        join
        repeat (3) begin
            @(negedge clk);
            check_eq("err_sticky", o_err_drop, 1);
        end
        @(posedge clk);
        #1;
        prep(1'b1, 32'h0000_0004, 10'd2, 8'h62, 16'h0A0B, 12'd8);
        run_req();
        check_eq("err_cleared", o_err_drop, 0);

        rand_side  = 1'b1;
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            i_cfg_bus_number      = 8'($urandom);
            i_cfg_device_number   = 5'($urandom);
            i_cfg_function_number = 3'($urandom);
            prep(1'($urandom), $urandom,
                 (($urandom % 20) == 0) ? 10'd0 : 10'($urandom_range(1, 16)),
                 8'($urandom), 16'($urandom), 12'($urandom));
            run_req();
        end
        rand_side   = 1'b0;
        tx_cfg_req  = 1'b0;
        tx_err_drop = 1'b0;
        tx_buf_av   = 6'd2;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcie_axi_tx_tlp_gen.md
PCIE_AXI_TX_TLP_GEN -- requirements
Module: pcie_axi_tx_tlp_gen

Interface
REQ-001 Parameter BUF_AV_MIN, default 2: minimum tx_buf_av value required before a TLP may start.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_cfg_bus_number / i_cfg_device_number / i_cfg_function_number  in  8/5/3  local ID, used as requester ID (MWr) or completer ID (CplD).
REQ-005 i_req_stb  in  1  request valid; level, held until o_req_ack.
REQ-006 o_req_ack  out  1  one-cycle pulse: request captured.
REQ-007 i_req_type  in  1  0 = MWr32, 1 = CplD.
REQ-008 i_req_addr  in  32  MWr byte address ([1:0] ignored); CplD lower address = [6:0].
REQ-009 i_req_dword_count  in  10  payload length; 0 means 1024.
REQ-010 i_req_tag / i_req_requester_id / i_req_byte_count  in  8/16/12  CplD fields; tag also sent in MWr.
REQ-011 i_data, i_data_valid / o_data_ready  in, in / out  32, 1 / 1  payload source handshake.
REQ-012 s_axis_tx_tdata/tkeep/tuser/tlast/tvalid  out  32/4/4/1/1; s_axis_tx_tready  in  1  AXI4-Stream to PCIe core.
REQ-013 tx_buf_av  in  6; tx_err_drop  in  1; tx_cfg_req  in  1; tx_cfg_gnt  out  1.
REQ-014 o_busy  out  1  state != IDLE; o_done  out  1  pulse on final beat accepted; o_err_drop  out  1  sticky drop flag.

Function
REQ-015 States: IDLE, HDR0, HDR1, HDR2, DATA; one beat per state per tready-qualified transfer.
REQ-016 IDLE->HDR0 when i_req_stb=1, tx_cfg_req=0, tx_buf_av>=BUF_AV_MIN; same cycle o_req_ack=1 and all request fields registered.
REQ-017 tx_cfg_gnt=1 only in IDLE while tx_cfg_req=1; never during a packet; request acceptance blocked that cycle.
REQ-018 MWr DW0 = {8'h40, 8'h00, 6'b0, len}; DW1 = {bus,dev,fun, tag, last_be, 4'hF}, last_be=4'h0 if length=1 else 4'hF; DW2 = {addr[31:2], 2'b00}.
REQ-019 CplD DW0 = {8'h4A, 8'h00, 6'b0, len}; DW1 = {bus,dev,fun, 3'b000, 1'b0, byte_count}; DW2 = {requester_id, tag, 1'b0, addr[6:0]}.
REQ-020 Header beats registered: tvalid=1 in HDRx; tdata stable until tready=1; advance only on tvalid&&tready.
REQ-021 DATA: s_axis_tx_tvalid=i_data_valid, tdata=i_data, o_data_ready=s_axis_tx_tready (combinational, zero latency); o_data_ready=0 outside DATA.
REQ-022 11-bit beat counter loaded with length (1024 for 0); decrements per accepted data beat; tlast=1 when counter=1 and tvalid=1.
REQ-023 Final beat accepted -> IDLE, o_done=1 that cycle; next request earliest following cycle.
REQ-024 Gaps in i_data_valid mid-packet drop tvalid, do not abort; counter holds.
REQ-025 tkeep=4'hF and tuser=4'h0 on every beat.
REQ-026 tx_err_drop=1 any cycle sets o_err_drop; cleared on next o_req_ack (set wins if same cycle).
REQ-027 tx_buf_av checked only at start; falls mid-packet ignored.

Reset
REQ-028 On rst: state IDLE; tvalid, tlast, o_req_ack, o_done, o_busy, o_err_drop, tx_cfg_gnt, o_data_ready = 0; tdata = 0; counter = 0.
REQ-029 rst mid-packet: outputs take reset values next edge; partial TLP abandoned, no o_done.

Structure
REQ-030 Shared package pcie_tlp_pkg: fmt/type byte constants (8'h40, 8'h4A), state encoding, header field widths.
REQ-031 One sub-module pcie_tx_hdr_fmt: combinational 3-DW header builder from registered request fields and type.

Verification
REQ-032 MWr, addr 32'h0000_1004, len 1, tready=1 -> beats 32'h40000001, {ID,tag,8'h0F}, 32'h00001004, data with tlast; o_done on beat 4.
REQ-033 CplD, len 4, byte_count 16, addr[6:0]=7'h10, tag 8'h05 -> DW0 32'h4A000004, DW2 low byte 8'h10, 4 data beats, tlast on 4th only.
REQ-034 tready toggled 1/0 per cycle during header and data -> tdata stable while tready=0; exactly 3+len beats transferred.
REQ-035 tx_cfg_req=1 with i_req_stb=1 in IDLE -> tx_cfg_gnt=1, no o_req_ack until tx_cfg_req=0; tx_buf_av=1 -> no start.
REQ-036 len 0 -> 1024 data beats, tlast on 1024th; rst asserted at data beat 10 -> tvalid=0 next cycle, no o_done.
REQ-037 tx_err_drop pulse mid-packet -> o_err_drop=1 held until next o_req_ack.
